fft_out_unload: RTL

FFT_OUT_UNLOAD -- requirements
Module: fft_out_unload

---
 rtl/fft_out_unload.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fft_out_unload.sv
// ============================================================================
// Module      : fft_out_unload
// Description : Captures a 32-point FFT final-stage frame and streams it out
//               one bin per clock over a valid/ready handshake.
//               FFT_OUT_BITREV_EN: read bin k from element bitrev5(k).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_out_unload (
    input  logic         clk_MAC,
    input  logic         rst,
    input  logic         load,
    input  logic [511:0] din_r,
    input  logic [511:0] din_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [15:0]  out_r,
    output logic [15:0]  out_i,
    output logic [4:0]   out_idx,
    output logic         out_last,
    output logic         load_err
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [4:0] c_LAST_BIN = 5'd31;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_bin;
    logic [4:0]  w_bin_nxt;
    logic        w_transfer;
    logic        w_capture;
    logic        w_drop;
    logic        w_advance;
    logic [4:0]  w_rd_sel;
    logic [15:0] w_nxt_r;
    logic [15:0] w_nxt_i;
    logic [15:0] r_buf_r [32];
    logic [15:0] r_buf_i [32];

    function automatic logic [4:0] f_map(input logic [4:0] k);
`ifdef FFT_OUT_BITREV_EN
        return {k[0], k[1], k[2], k[3], k[4]};
`else
        return k;
`endif
    endfunction

    always_ff @(posedge clk_MAC or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_bin   <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_bin   <= w_bin_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bin_nxt   = r_bin;
        w_transfer  = (r_state == STREAM) && out_ready;
        // A load is only accepted when idle or on the closing bin-31 transfer.
        w_capture   = load && ((r_state == IDLE) || (w_transfer && (r_bin == c_LAST_BIN)));
        w_drop      = load && (r_state == STREAM) && !w_capture;
        w_advance   = w_transfer && (r_bin != c_LAST_BIN);
        if (w_capture) begin
            w_state_nxt = STREAM;
            w_bin_nxt   = 5'd0;
        end else if (w_transfer) begin
            if (r_bin == c_LAST_BIN) begin
                w_state_nxt = IDLE;
                w_bin_nxt   = 5'd0;
            end else begin
                w_bin_nxt   = r_bin + 5'd1;
            end
        end
        // On capture the buffer is not yet written, so bin 0 comes from the inputs.
        w_rd_sel = f_map(w_bin_nxt);
        if (w_capture) begin
            w_nxt_r = din_r[{w_rd_sel, 4'd0} +: 16];
            w_nxt_i = din_i[{w_rd_sel, 4'd0} +: 16];
        end else begin
            w_nxt_r = r_buf_r[w_rd_sel];
            w_nxt_i = r_buf_i[w_rd_sel];
        end
    end

    always_ff @(posedge clk_MAC) begin
        if (w_capture) begin
            for (int k = 0; k < 32; k++) begin
                r_buf_r[k] <= din_r[16*k +: 16];
                r_buf_i[k] <= din_i[16*k +: 16];
            end
        end
    end

    always_ff @(posedge clk_MAC or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_idx   <= 5'd0;
            out_last  <= 1'b0;
            load_err  <= 1'b0;
            out_r     <= 16'd0;
            out_i     <= 16'd0;
        end else begin
            out_valid <= (w_state_nxt == STREAM);
            out_idx   <= w_bin_nxt;
            out_last  <= (w_state_nxt == STREAM) && (w_bin_nxt == c_LAST_BIN);
            load_err  <= w_drop;
            if (w_capture || w_advance) begin
                out_r <= w_nxt_r;
                out_i <= w_nxt_i;
            end
        end
    end

endmodule

`default_nettype wire
